// File: rtl/yolo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : yolo_pkg
// Brief   : Shared widths, int8 limits and accumulator sizing check for the
//           convolution / activation datapath.
// Revision: 1.0 - initial release
// ============================================================================
package yolo_pkg;

  localparam int DATA_W   = 8;
  localparam int BIAS_W   = 16;
  localparam int ACC_W    = 24;
  localparam int TAPS     = 9;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // True when an accumulator of acc_w bits can hold taps full-scale products
  // plus a sign bit without ever wrapping.
  function automatic bit acc_w_ok(input int acc_w, input int data_w, input int taps);
    return acc_w >= (2 * data_w + $clog2(taps) + 1);
  endfunction

  localparam bit ACC_W_LEGAL = acc_w_ok(ACC_W, DATA_W, TAPS);

endpackage : yolo_pkg
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// Module  : requant_sat
// Brief   : Combinational round-half-up arithmetic right shift followed by
//           saturation of a wide signed sum to a narrow signed value.
// Revision: 1.0 - initial release
// ============================================================================
module requant_sat
  import yolo_pkg::*;
#(
  parameter int ACC_W  = yolo_pkg::ACC_W,
  parameter int DATA_W = yolo_pkg::DATA_W,
  parameter int SHIFT  = 4
) (
  input  logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] value,
  output logic              sat
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_V =
    $signed({{(EXT_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
  localparam logic signed [EXT_W-1:0] MIN_V =
    $signed({{(EXT_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}});

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  assign ext = $signed({sum[ACC_W-1], sum});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [EXT_W-1:0] HALF = {{(EXT_W - 1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign rounded = ext + $signed(HALF);
    end else begin : g_no_round
      assign rounded = ext;
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;

  // Clamp the shifted value into the signed output range and flag clipping.
  always_comb begin
    value = shifted[DATA_W-1:0];
    sat   = 1'b0;
    if (shifted > MAX_V) begin
      value = MAX_V[DATA_W-1:0];
      sat   = 1'b1;
    end else if (shifted < MIN_V) begin
      value = MIN_V[DATA_W-1:0];
      sat   = 1'b1;
    end
  end

endmodule : requant_sat
`default_nettype wire

// File: rtl/conv_mac_accum.sv
`default_nettype none
// ============================================================================
// Module  : conv_mac_accum
// Brief   : Streaming MAC over one convolution window with bias, then
//           requantisation to int8 into a single-entry output register.
// Revision: 1.0 - initial release
// ============================================================================
module conv_mac_accum
  import yolo_pkg::*;
#(
  parameter int DATA_W = yolo_pkg::DATA_W,
  parameter int BIAS_W = yolo_pkg::BIAS_W,
  parameter int ACC_W  = yolo_pkg::ACC_W,
  parameter int TAPS   = yolo_pkg::TAPS,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_act,
  input  logic [DATA_W-1:0] in_wgt,
  input  logic [BIAS_W-1:0] in_bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int  PROD_W = 2 * DATA_W;
  localparam int  CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam bit  ACC_OK = acc_w_ok(ACC_W, DATA_W, TAPS);

  generate
    if (!ACC_OK) begin : g_acc_w_check
      $error("conv_mac_accum: ACC_W too small for DATA_W/TAPS");
    end
  endgenerate

  logic [CNT_W-1:0]  tap_cnt;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  bias_ext;
  logic [ACC_W-1:0]  sum_next;
  logic [DATA_W-1:0] rq_value;
  logic              rq_sat;
  logic              accept;
  logic              last_tap;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_tap = (tap_cnt == LAST_TAP);
  assign busy     = (tap_cnt != '0);

  assign prod     = PROD_W'($signed(in_act) * $signed(in_wgt));
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W - BIAS_W){in_bias[BIAS_W-1]}}, in_bias};

  // Tap 0 seeds the sum with the bias; later taps add onto the running total.
  // On the last tap this is the final window sum fed to requantisation.
  assign sum_next = ((tap_cnt == '0) ? bias_ext : acc) + prod_ext;

  requant_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_requant_sat (
    .sum   (sum_next),
    .value (rq_value),
    .sat   (rq_sat)
  );

  // Accumulator and tap counter advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (accept) begin
      acc     <= sum_next;
      tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
    end
  end

  // Output register: loads on a last-tap accept (even while draining), clears
  // valid on a plain drain, and holds data/sat stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (accept && last_tap) begin
      out_valid <= 1'b1;
      out_data  <= rq_value;
      out_sat   <= rq_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : conv_mac_accum
`default_nettype wire

// File: doc/conv_mac_accum.md
Name: conv_mac_accum

Overview:
- Streaming multiply-accumulate and requantisation stage for one output pixel of a convolution window.
- Accepts TAPS signed int8 activation/weight pairs per window and adds a per-channel bias.
- Rounds, right-shifts and saturates the sum to int8.
- Sits directly upstream of the LeakyReLU activation; out_data drives its 8-bit two's-complement input_data.

Parameters:
- DATA_W, 8: activation, weight and output width (signed).
- BIAS_W, 16: bias width (signed).
- ACC_W, 24: accumulator width. Must be at least 2*DATA_W + clog2(TAPS) + 1; the accumulator never wraps by construction.
- TAPS, 9: products per window (3x3 kernel).
- SHIFT, 4: requantisation right shift, range 0..ACC_W-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_act  in  DATA_W  signed activation.
- in_wgt  in  DATA_W  signed weight.
- in_bias  in  BIAS_W  signed bias; sampled only on the first tap of a window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  saturated signed result.
- out_sat  out  1  out_data was clipped; qualified by out_valid.
- busy  out  1  tap counter is nonzero (partial window held).

Behaviour:
- Reset: out_valid=0, out_data=0, out_sat=0, busy=0, tap counter=0, accumulator=0. A partial window is discarded.
- Input handshake: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_ready). No input beat is accepted while a result is stalled.
- Product: signed in_act * in_wgt, 2*DATA_W bits, sign-extended to ACC_W.
- Tap 0: acc <= sext(in_bias) + product.
- Taps 1..TAPS-1: acc <= acc + product.
- Tap counter: increments per accepted beat and wraps to 0 after tap TAPS-1. No idle gap is required between windows.
- Last tap (TAPS-1) accepted at cycle t:
  - final = acc + product (combinational).
  - r = (final + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift, round-half-up.
  - out_data = clamp(r, -2^(DATA_W-1), 2^(DATA_W-1)-1).
  - out_sat = (r != out_data).
  - Result is registered; out_valid=1 from cycle t+1. Latency is 1 cycle from the last tap.
- Output hold: while out_valid && !out_ready, out_data and out_sat are stable.
- Output drains: out_valid && out_ready with no new last-tap accept in the same cycle clears out_valid next cycle.
- Simultaneous drain and last-tap accept: new result loads and out_valid stays 1. There are no bubbles and no lost results.
- in_valid low mid-window: the accumulator and counter hold indefinitely.
- rst mid-window or with a stalled result: everything is cleared; the stalled result is dropped.
- Internal states: ACCUM (counter 0..TAPS-1) and an independent output-register valid flag; no separate FSM is needed.

Decomposition:
- Shared package yolo_pkg holds:
  - DATA_W, ACC_W, BIAS_W defaults.
  - INT8_MAX=127 and INT8_MIN=-128.
  - the clog2-based ACC_W legality check constant.
- One combinational sub-module, requant_sat (inputs: ACC_W sum; outputs: DATA_W value and sat flag), parameterised by SHIFT. The LeakyReLU path can reuse it later.
- Counter, accumulator and output register stay in conv_mac_accum.

Test Plan:
- Positive window: TAPS=9, SHIFT=4, bias=0, 9 beats act=10, wgt=10 -> out_data=56 (0x38), out_sat=0, out_valid one cycle after 9th accept.
- Negative window: same stimulus with act=-10 (0xF6) -> sum -900, out_data=-56 (0xC8, 200 unsigned), out_sat=0.
- Saturation:
  - act=127, wgt=127 x9 -> out_data=127 (0x7F), out_sat=1.
  - act=-128, wgt=127 x9 -> out_data=-128 (0x80), out_sat=1.
- Bias and rounding: bias=40 on tap 0, all act=0 -> out_data=3. Bias presented on taps 1..8 must be ignored (drive 0x7FFF there; result still 3).
- Backpressure and back-to-back:
  - Hold out_ready=0 after a result -> in_ready=0, out_data stable for 5 cycles.
  - Raise out_ready while presenting the next window's beats -> first beat accepted in the drain cycle.
  - Two consecutive windows yield 56 then -56 with no gap.
- Reset mid-window: accept 5 beats, assert rst 1 cycle, then the full positive window -> out_data=56; busy=0 and out_valid=0 immediately after reset.
